// File: rtl/crc_stream_if.sv
// Beat-in / CRC-out handshake bundle for crc_stream.
interface crc_stream_if #(
  parameter int DATA_W = 256
) ();
  localparam int BW = $clog2(DATA_W / 8 + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [BW-1:0]     in_bytes;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       crc_out;
  logic [15:0]       out_len;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, crc_out, out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, crc_out, out_len
  );
endinterface

// File: rtl/crc_stream.sv
// Streaming CRC engine: folds BPC bytes per clock of each DATA_W-bit beat into a
// running CRC and presents the final CRC and byte count on a held handshake.
module crc_stream #(
  parameter int          DATA_W  = 256,
  parameter int          BPC     = 8,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
  parameter bit          REFLECT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  crc_stream_if.slave bus
);
  localparam int NB  = DATA_W / 8;
  localparam int BW  = $clog2(NB + 1);
  localparam int K   = NB / BPC;
  localparam int CYW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q;
  logic              last_q;
  logic [BW-1:0]     rem_q;
  logic [CYW-1:0]    cyc_q;
  logic [31:0]       crc_q;
  logic [15:0]       cnt_q;
  logic              in_ready_q, out_valid_q;
  logic [31:0]       crc_out_q;
  logic [15:0]       out_len_q;

  logic [BW-1:0]     eff_bytes;
  logic [BW-1:0]     nfold;
  logic [31:0]       crc_fold;
  logic [16:0]       cnt_sum;
  logic [15:0]       cnt_fold;
  logic              accept, calc_done, out_hs;

  function automatic logic [7:0] reflect8(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The running CRC stays in the MSB-first domain; with REFLECT the input byte is
  // mirrored here and the register is mirrored once at the end, which matches the
  // reflected-polynomial LSB-first formulation bit for bit.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic [7:0]  bb;
    bb = REFLECT ? reflect8(b) : b;
    r  = c ^ {bb, 24'h0};
    for (int unsigned i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  assign accept    = (state_q == IDLE) && in_ready_q && bus.in_valid;
  assign calc_done = (state_q == CALC) && (cyc_q == CYW'(K - 1));
  assign out_hs    = (state_q == OUT) && out_valid_q && bus.out_ready;

  always_comb begin
    eff_bytes = BW'(NB);
    if (bus.in_last && (bus.in_bytes != '0) && (bus.in_bytes <= BW'(NB)))
      eff_bytes = bus.in_bytes;
  end

  // Only the leading rem_q bytes of the buffer are live; the rest pass through.
  always_comb begin
    crc_fold = crc_q;
    for (int unsigned j = 0; j < BPC; j++) begin
      if (j < 32'(rem_q)) crc_fold = crc_step(crc_fold, buf_q[DATA_W-1-8*j -: 8]);
    end
    nfold    = (rem_q > BW'(BPC)) ? BW'(BPC) : rem_q;
    cnt_sum  = {1'b0, cnt_q} + 17'(nfold);
    cnt_fold = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (calc_done) state_d = last_q ? OUT : IDLE;
      OUT:     if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      crc_out_q   <= '0;
      out_len_q   <= '0;
      crc_q       <= INIT;
      cnt_q       <= '0;
      buf_q       <= '0;
      last_q      <= 1'b0;
      rem_q       <= '0;
      cyc_q       <= '0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == OUT);
      case (state_q)
        IDLE: begin
          if (accept) begin
            buf_q  <= bus.in_data;
            last_q <= bus.in_last;
            rem_q  <= eff_bytes;
            cyc_q  <= '0;
          end
        end
        CALC: begin
          crc_q <= crc_fold;
          cnt_q <= cnt_fold;
          rem_q <= rem_q - nfold;
          buf_q <= buf_q << (8 * BPC);
          cyc_q <= cyc_q + CYW'(1);
          if (calc_done && last_q) begin
            crc_out_q <= (REFLECT ? reflect32(crc_fold) : crc_fold) ^ XOROUT;
            out_len_q <= cnt_fold;
          end
        end
        OUT: begin
          if (out_hs) begin
            crc_q <= INIT;
            cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.out_len   = out_len_q;
endmodule

// File: tb/tb_crc_stream.sv
// Directed checks of crc_stream with the default 256-bit/8-BPC build and a
// 32-bit/1-BPC build, using known CRC-32 check values and a bit-serial reference.
module tb_crc_stream;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  crc_stream_if #(.DATA_W(256)) bus_a ();
  crc_stream_if #(.DATA_W(32))  bus_b ();

  crc_stream #(.DATA_W(256), .BPC(8)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  crc_stream #(.DATA_W(32),  .BPC(1)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Reflected bit-serial CRC-32 over the first n bytes (byte 0 at the MSB end).
  function automatic logic [31:0] crc32_ref(input logic [255:0] d, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[255-8*i -: 8]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic send_a(input logic [255:0] d, input logic last, input logic [5:0] nb);
    int t;
    t = 0;
    bus_a.in_data = d; bus_a.in_last = last; bus_a.in_bytes = nb; bus_a.in_valid = 1'b1;
    while (bus_a.in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    total++;
    if (t >= 200) begin bad++; $display("FAIL send_a_ready got=%b want=1", bus_a.in_ready); end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
    t = 0;
    bus_b.in_data = d; bus_b.in_last = last; bus_b.in_bytes = nb; bus_b.in_valid = 1'b1;
    while (bus_b.in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    total++;
    if (t >= 200) begin bad++; $display("FAIL send_b_ready got=%b want=1", bus_b.in_ready); end
    @(negedge clk);
    bus_b.in_valid = 1'b0;
  endtask

  task automatic wait_a_out(output int n);
    n = 0;
    while (bus_a.out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic wait_b_out(output int n);
    n = 0;
    while (bus_b.out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic wait_b_ready(output int n);
    n = 0;
    while (bus_b.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    bus_a.in_valid = 1'b1; bus_b.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b0 || bus_a.crc_out !== 32'h0 ||
          bus_a.out_len !== 16'h0)
        begin bad++; $display("FAIL reset_a got v=%b r=%b crc=%h len=%h want 0 0 0 0",
          bus_a.out_valid, bus_a.in_ready, bus_a.crc_out, bus_a.out_len); end
      total++;
      if (bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b0)
        begin bad++; $display("FAIL reset_b got v=%b r=%b want 0 0", bus_b.out_valid, bus_b.in_ready); end
    end
    rst = 1'b1; bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0)
      begin bad++; $display("FAIL release got ra=%b rb=%b va=%b want 1 1 0",
        bus_a.in_ready, bus_b.in_ready, bus_a.out_valid); end
  endtask

  task automatic test_single_beat();
    logic [255:0] d;
    int n;
    d = rnd256();
    d[255 -: 72] = 72'h313233343536373839;
    send_a(d, 1'b1, 6'd9);
    wait_a_out(n);
    total++;
    if (n != 4) begin bad++; $display("FAIL single_latency got=%0d want=4", n); end
    total++;
    if (bus_a.crc_out !== 32'hCBF43926) begin bad++; $display("FAIL single_crc got=%h want=cbf43926", bus_a.crc_out); end
    total++;
    if (bus_a.out_len !== 16'd9) begin bad++; $display("FAIL single_len got=%0d want=9", bus_a.out_len); end
    @(negedge clk);
    total++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1)
      begin bad++; $display("FAIL single_hs got v=%b r=%b want 0 1", bus_a.out_valid, bus_a.in_ready); end
  endtask

  task automatic test_multi_beat();
    logic [31:0] d;
    int n;
    send_b(32'h31323334, 1'b0, 3'd0);
    wait_b_ready(n);
    total++;
    if (n != 4) begin bad++; $display("FAIL multi_ready1 got=%0d want=4", n); end
    send_b(32'h35363738, 1'b0, 3'd0);
    wait_b_ready(n);
    total++;
    if (n != 4) begin bad++; $display("FAIL multi_ready2 got=%0d want=4", n); end
    d = $urandom();
    d[31:24] = 8'h39;
    send_b(d, 1'b1, 3'd1);
    wait_b_out(n);
    total++;
    if (n != 4) begin bad++; $display("FAIL multi_latency got=%0d want=4", n); end
    total++;
    if (bus_b.crc_out !== 32'hCBF43926) begin bad++; $display("FAIL multi_crc got=%h want=cbf43926", bus_b.crc_out); end
    total++;
    if (bus_b.out_len !== 16'd9) begin bad++; $display("FAIL multi_len got=%0d want=9", bus_b.out_len); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    int n;
    bus_a.out_ready = 1'b0;
    d = rnd256();
    d[255 -: 24] = 24'h616263;
    send_a(d, 1'b1, 6'd3);
    wait_a_out(n);
    d = rnd256();
    d[255 -: 8] = 8'h61;
    bus_a.in_data = d; bus_a.in_last = 1'b1; bus_a.in_bytes = 6'd1; bus_a.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0 || bus_a.crc_out !== 32'h352441C2 ||
          bus_a.out_len !== 16'd3)
        begin bad++; $display("FAIL hold_abc cyc=%0d got v=%b r=%b crc=%h len=%0d want 1 0 352441c2 3",
          i, bus_a.out_valid, bus_a.in_ready, bus_a.crc_out, bus_a.out_len); end
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1)
      begin bad++; $display("FAIL hold_release got v=%b r=%b want 0 1", bus_a.out_valid, bus_a.in_ready); end
    send_a(d, 1'b1, 6'd1);
    wait_a_out(n);
    total++;
    if (bus_a.crc_out !== 32'hE8B7BE43 || bus_a.out_len !== 16'd1)
      begin bad++; $display("FAIL b2b_a got crc=%h len=%0d want e8b7be43 1", bus_a.crc_out, bus_a.out_len); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [255:0] d;
    int n;
    send_a(rnd256(), 1'b0, 6'd0);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b0)
      begin bad++; $display("FAIL midrst_hold got v=%b r=%b want 0 0", bus_a.out_valid, bus_a.in_ready); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus_a.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", bus_a.in_ready); end
    d = rnd256();
    d[255 -: 8] = 8'h61;
    send_a(d, 1'b1, 6'd1);
    wait_a_out(n);
    total++;
    if (bus_a.crc_out !== 32'hE8B7BE43 || bus_a.out_len !== 16'd1)
      begin bad++; $display("FAIL midrst_a got crc=%h len=%0d want e8b7be43 1", bus_a.crc_out, bus_a.out_len); end
    @(negedge clk);
  endtask

  task automatic test_full_mask();
    logic [255:0] d;
    logic [5:0]   nbv [4];
    int           want_len [4];
    logic [31:0]  exp_crc;
    int n;
    d = rnd256();
    nbv[0] = 6'd0;  want_len[0] = 32;
    nbv[1] = 6'd32; want_len[1] = 32;
    nbv[2] = 6'd40; want_len[2] = 32;
    nbv[3] = 6'd5;  want_len[3] = 5;
    for (int i = 0; i < 4; i++) begin
      exp_crc = crc32_ref(d, want_len[i]);
      send_a(d, 1'b1, nbv[i]);
      wait_a_out(n);
      total++;
      if (bus_a.crc_out !== exp_crc || bus_a.out_len !== 16'(want_len[i]))
        begin bad++; $display("FAIL mask_nb%0d got crc=%h len=%0d want %h %0d",
          nbv[i], bus_a.crc_out, bus_a.out_len, exp_crc, want_len[i]); end
      @(negedge clk);
    end
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0; bus_a.in_bytes = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0; bus_b.in_bytes = '0;
    bus_b.out_ready = 1'b1;
    @(posedge clk);
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_back_to_back();
    test_mid_reset();
    test_full_mask();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
